lsu_mem_port: RTL

// - Parametrised load/store unit between the CPU datapath and word-addressed data memory.
// - Replaces fixed single-cycle LB/LH/LW readdata slicing with a handshaked, multi-cycle port.
// - Adds stores with byte enables, unsigned loads, misalignment detection and memory wait states.
// - Sits between the execute stage (byte address from ALU) and the data memory / bus.

---
 rtl/lsu_mem_port.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// Handshaked load/store port between the execute stage and word-addressed data memory.
// Define LSU_TIMEOUT_EN to abort ACCESS after TIMEOUT consecutive mem_ready=0 cycles.
module lsu_mem_port #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_error,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_write,
    output logic [XLEN/8-1:0]   mem_byteen,
    output logic [XLEN-1:0]     mem_writedata,
    input  logic [XLEN-1:0]     mem_readdata,
    input  logic                mem_ready
);
    localparam int STRB = XLEN / 8;
    localparam int L    = $clog2(STRB);

    if ((XLEN != 32 && XLEN != 64) || TIMEOUT < 1) begin : g_param_check
        $error("lsu_mem_port: XLEN must be 32 or 64 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state, state_nxt;
    logic [2:0]     funct3_q;
    logic [L-1:0]   off_q;
    logic           accept;
    logic           legal;
    logic           timed_out;

    function automatic logic funct3_illegal(input logic [2:0] f3, input logic wr);
        funct3_illegal = (f3 == 3'b011 && XLEN == 32) || (f3 == 3'b110) ||
                         (f3 == 3'b111) || (wr && f3[2]);
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] a);
        case (f3[1:0])
            2'b01:   is_aligned = !a[0];
            2'b10:   is_aligned = (a[1:0] == 2'b00);
            2'b11:   is_aligned = (a == 3'b000);
            default: is_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [STRB-1:0] lane_enables(input logic [2:0] f3, input logic [L-1:0] off);
        case (f3[1:0])
            2'b00:   lane_enables = STRB'(1) << off;
            2'b01:   lane_enables = STRB'(3) << off;
            2'b10:   lane_enables = STRB'(15) << off;
            default: lane_enables = '1;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by access size.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [2:0] f3,
                                                    input logic [L-1:0] off);
        logic        [XLEN-1:0] lane;
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [31:0]     w;
        lane = rdata >> {off, 3'b000};
        b = lane[7:0];
        h = lane[15:0];
        w = lane[31:0];
        case (f3)
            3'b000:  load_extend = XLEN'(b);
            3'b001:  load_extend = XLEN'(h);
            3'b010:  load_extend = XLEN'(w);
            3'b100:  load_extend = XLEN'(lane[7:0]);
            3'b101:  load_extend = XLEN'(lane[15:0]);
            default: load_extend = lane;
        endcase
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign legal      = !funct3_illegal(req_funct3, req_write) && is_aligned(req_funct3, req_addr[2:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == ACCESS) && !mem_ready && (wait_cnt == CNT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? ACCESS : RESP;
            ACCESS:  if (mem_ready || timed_out) state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs are loaded on accept, held through ACCESS and cleared on leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q      <= '0;
            off_q         <= '0;
            resp_rdata    <= '0;
            resp_error    <= 1'b0;
            mem_address   <= '0;
            mem_write     <= 1'b0;
            mem_byteen    <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q   <= req_funct3;
                        off_q      <= req_addr[L-1:0];
                        resp_rdata <= '0;
                        resp_error <= !legal;
                        if (legal) begin
                            mem_address   <= req_addr[ADDR_W+L-1:L];
                            mem_write     <= req_write;
                            mem_byteen    <= lane_enables(req_funct3, req_addr[L-1:0]);
                            mem_writedata <= req_wdata << {req_addr[L-1:0], 3'b000};
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready || timed_out) begin
                        resp_rdata    <= (mem_write || !mem_ready) ? '0
                                         : load_extend(mem_readdata, funct3_q, off_q);
                        resp_error    <= !mem_ready;
                        mem_address   <= '0;
                        mem_write     <= 1'b0;
                        mem_byteen    <= '0;
                        mem_writedata <= '0;
                    end
                end
                default: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
            endcase
        end
    end
endmodule
